// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Consumer-side controller for the core PLL rst/locked pair, clocked by refclk.
// It pulses the PLL reset, waits for lock with a timeout and retry, qualifies
// lock stability, then releases the core reset. Lock losses in RUN are counted
// and re-hold the core in reset until the PLL relocks.
//
// Optional feature macro: PLL_LOCK_DEGLITCH_EN
//   defined   : in RUN, lock loss needs lk=0 on 4 consecutive cycles
//   undefined : a single lk=0 cycle in RUN is a lock loss
//
// Release latency: number the first refclk rising edge with rst_n high as
// edge 1. With pll_locked already high, ready is high after edge
// max(RST_PULSE_CYC,2) + 1 + STABLE_CYC. The 2-cycle synchronizer latency
// overlaps the PLL reset pulse; the +1 is the WAIT_LOCK cycle that sees lk=1.
// For RST_PULSE_CYC=4, STABLE_CYC=8 this is edge 13.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 500000,
    parameter int STABLE_CYC       = 1024,
    parameter int TIMER_W          = 20,
    parameter int CNT_W            = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             pll_locked,
    input  logic             force_relock,
    output logic             pll_rst,
    output logic             core_rst_n,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] retry_cnt,
    output logic [CNT_W-1:0] loss_cnt
);

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_PULSE_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYC - 1);

    state_t             state_q;
    state_t             state_d;
    logic [TIMER_W-1:0] timer_q;
    logic [TIMER_W-1:0] timer_d;
    logic               sync_q;
    logic               lk;
    logic               lock_lost;
    logic               retry_inc;
    logic               loss_inc;

    // Two-flop synchronizer bringing the asynchronous pll_locked into refclk
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            lk     <= 1'b0;
        end else begin
            sync_q <= pll_locked;
            lk     <= sync_q;
        end
    end

`ifdef PLL_LOCK_DEGLITCH_EN
    logic [1:0] low_q;

    assign lock_lost = !lk && (low_q == 2'd3);

    // Count consecutive low lk cycles while staying in RUN; any high clears it
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            low_q <= 2'd0;
        end else if (state_q == RUN && state_d == RUN && !lk) begin
            low_q <= low_q + 2'd1;
        end else begin
            low_q <= 2'd0;
        end
    end
`else
    assign lock_lost = !lk;
`endif

    // Next-state and timer: force_relock beats lock events, which beat timer expiry
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TIMER_W'(1);
        retry_inc = 1'b0;
        loss_inc  = 1'b0;
        case (state_q)
            PLLRST: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end
            end
            WAIT_LOCK: begin
                if (force_relock) begin
                    state_d = PLLRST;
                    timer_d = '0;
                end else if (lk) begin
                    state_d = STABLE;
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d   = PLLRST;
                    timer_d   = '0;
                    retry_inc = 1'b1;
                end
            end
            STABLE: begin
                if (force_relock) begin
                    state_d = PLLRST;
                    timer_d = '0;
                end else if (!lk) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                end
            end
            RUN: begin
                timer_d = '0;
                if (force_relock) begin
                    state_d = PLLRST;
                end else if (lock_lost) begin
                    state_d  = WAIT_LOCK;
                    loss_inc = 1'b1;
                end
            end
            default: begin
                state_d = PLLRST;
                timer_d = '0;
            end
        endcase
    end

    // State, timer, registered outputs and saturating status counters
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PLLRST;
            timer_q    <= '0;
            pll_rst    <= 1'b1;
            core_rst_n <= 1'b0;
            ready      <= 1'b0;
            retry_cnt  <= '0;
            loss_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pll_rst    <= (state_d == PLLRST);
            core_rst_n <= (state_d == RUN);
            ready      <= (state_d == RUN);
            if (retry_inc && retry_cnt != '1) begin
                retry_cnt <= retry_cnt + CNT_W'(1);
            end
            if (loss_inc && loss_cnt != '1) begin
                loss_cnt <= loss_cnt + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Scoreboard bench: expected values are pushed when a scenario's stimulus is
// driven and popped against the DUT's observed behaviour. Works with or without
// PLL_LOCK_DEGLITCH_EN defined.
module tb_pll_lock_sequencer;

    localparam int RST_PULSE_CYC    = 4;
    localparam int LOCK_TIMEOUT_CYC = 100;
    localparam int STABLE_CYC       = 8;
    localparam int TIMER_W          = 20;
    localparam int CNT_W            = 8;

    // Edge numbers derived from the timing: sync takes 2 edges, WAIT_LOCK
    // needs 1 edge to see lk, STABLE needs STABLE_CYC edges.
    localparam int READY_EDGE = RST_PULSE_CYC + 1 + STABLE_CYC;                    // 13
    localparam int RETRY_GAP  = RST_PULSE_CYC + LOCK_TIMEOUT_CYC;                  // 104
    localparam int T2_READY   = 350 + 2 + 1 + STABLE_CYC;                          // 361

`ifdef PLL_LOCK_DEGLITCH_EN
    localparam int LOW_LEN     = 4;
    localparam int T3_FALL     = -1;
    localparam int T3_STATE    = -1;
    localparam int T3_LOSS     = 0;
    localparam int T3_BACK     = -1;
`else
    localparam int LOW_LEN     = 1;
    localparam int T3_FALL     = 3;
    localparam int T3_STATE    = 1;
    localparam int T3_LOSS     = 1;
    localparam int T3_BACK     = 3 + 1 + STABLE_CYC;                               // 12
`endif

    logic             refclk;
    logic             rst_n;
    logic             pll_locked;
    logic             force_relock;
    logic             pll_rst;
    logic             core_rst_n;
    logic             ready;
    logic [1:0]       state;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    typedef struct {
        string tag;
        int    value;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYC   (RST_PULSE_CYC),
        .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .STABLE_CYC      (STABLE_CYC),
        .TIMER_W         (TIMER_W),
        .CNT_W           (CNT_W)
    ) dut (
        .refclk      (refclk),
        .rst_n       (rst_n),
        .pll_locked  (pll_locked),
        .force_relock(force_relock),
        .pll_rst     (pll_rst),
        .core_rst_n  (core_rst_n),
        .ready       (ready),
        .state       (state),
        .retry_cnt   (retry_cnt),
        .loss_cnt    (loss_cnt)
    );

    // 100 MHz free-running bench clock
    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Hard stop in case something hangs despite the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input int value);
        exp_t e;
        e.tag   = tag;
        e.value = value;
        exp_q.push_back(e);
    endtask

    task automatic popCheck(input int observed);
        exp_t e;
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            checkOutput(e.tag, observed, e.value);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic applyReset(input logic locked);
        rst_n        = 1'b0;
        pll_locked   = locked;
        force_relock = 1'b0;
        repeat (3) tick();
        @(negedge refclk);
        rst_n = 1'b1;
    endtask

    task automatic waitReady(input string tag, input int limit);
        int n;
        n = 0;
        while (!ready && n < limit) begin
            tick();
            n++;
        end
        if (!ready) checkOutput(tag, 0, 1);
    endtask

    initial begin
        int n, high, ready_edge, fall, back, st, prst;
        int st3, cr3, st5, st6, st7;
        int rises, first_rise, last_rise, cur_w, min_w, max_w;
        int drops, timeouts;
        logic prev;
        bit seen_low;

        // ---- Reset state ----
        rst_n        = 1'b0;
        pll_locked   = 1'b1;
        force_relock = 1'b0;
        pushExpect("rst_pll_rst", 1);
        pushExpect("rst_core_rst_n", 0);
        pushExpect("rst_ready", 0);
        pushExpect("rst_state", 0);
        pushExpect("rst_retry", 0);
        pushExpect("rst_loss", 0);
        repeat (3) tick();
        popCheck(int'(pll_rst));
        popCheck(int'(core_rst_n));
        popCheck(int'(ready));
        popCheck(int'(state));
        popCheck(int'(retry_cnt));
        popCheck(int'(loss_cnt));

        // ---- 1: cold start with lock held high ----
        pushExpect("t1_pll_rst_cycles", RST_PULSE_CYC);
        pushExpect("t1_ready_edge", READY_EDGE);
        pushExpect("t1_retry", 0);
        pushExpect("t1_loss", 0);
        pushExpect("t1_state", 3);
        @(negedge refclk);
        rst_n = 1'b1;
        high       = int'(pll_rst);
        ready_edge = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (pll_rst) high++;
            if (ready) begin
                ready_edge = i;
                break;
            end
        end
        popCheck(high);
        popCheck(ready_edge);
        popCheck(int'(retry_cnt));
        popCheck(int'(loss_cnt));
        popCheck(int'(state));

        // ---- 3: single-cycle lock drop in RUN ----
        pushExpect("t3_fall_edge", T3_FALL);
        pushExpect("t3_state_at_fall", T3_STATE);
        pushExpect("t3_relock_edge", T3_BACK);
        pushExpect("t3_pll_rst_cycles", 0);
        pushExpect("t3_loss", T3_LOSS);
        pushExpect("t3_retry", 0);
        pll_locked = 1'b0;
        fall = -1; back = -1; st = -1; prst = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) pll_locked = 1'b1;
            if (pll_rst) prst++;
            if (!core_rst_n && fall < 0) begin
                fall = i;
                st   = int'(state);
            end
            if (fall >= 0 && ready && back < 0) back = i;
        end
        popCheck(fall);
        popCheck(st);
        popCheck(back);
        popCheck(prst);
        popCheck(int'(loss_cnt));
        popCheck(int'(retry_cnt));

        // ---- 5: force_relock in RUN on the same edge as an lk drop ----
        pushExpect("t5_state", 0);
        pushExpect("t5_core_rst_n", 0);
        pushExpect("t5_pll_rst_cycles", RST_PULSE_CYC);
        pushExpect("t5_ready_edge", 3 + RST_PULSE_CYC + 1 + STABLE_CYC);
        pushExpect("t5_loss", T3_LOSS);
        pll_locked = 1'b0;
        st3 = -1; cr3 = -1; prst = 0; back = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) pll_locked = 1'b1;
            if (i == 2) force_relock = 1'b1;
            if (i == 3) begin
                force_relock = 1'b0;
                st3 = int'(state);
                cr3 = int'(core_rst_n);
            end
            if (pll_rst) prst++;
            if (i > 3 && ready && back < 0) back = i;
        end
        popCheck(st3);
        popCheck(cr3);
        popCheck(prst);
        popCheck(back);
        popCheck(int'(loss_cnt));

        // ---- 2: lock absent for 350 cycles -> three timeout retries ----
        pushExpect("t2_retry_pulses", 3);
        pushExpect("t2_first_retry_edge", RETRY_GAP);
        pushExpect("t2_retry_span", 2 * RETRY_GAP);
        pushExpect("t2_min_width", RST_PULSE_CYC);
        pushExpect("t2_max_width", RST_PULSE_CYC);
        pushExpect("t2_ready_edge", T2_READY);
        pushExpect("t2_retry_cnt", 3);
        applyReset(1'b0);
        prev = 1'b1;
        rises = 0; first_rise = -1; last_rise = -1;
        cur_w = 0; min_w = 9999; max_w = -1; ready_edge = -1;
        for (int i = 1; i <= 600; i++) begin
            tick();
            if (i == 350) pll_locked = 1'b1;
            if (pll_rst && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = i;
                last_rise = i;
                cur_w = 1;
            end else if (pll_rst && rises > 0) begin
                cur_w++;
            end else if (!pll_rst && prev && rises > 0) begin
                if (cur_w < min_w) min_w = cur_w;
                if (cur_w > max_w) max_w = cur_w;
            end
            prev = pll_rst;
            if (ready) begin
                ready_edge = i;
                break;
            end
        end
        popCheck(rises);
        popCheck(first_rise);
        popCheck(last_rise - first_rise);
        popCheck(min_w);
        popCheck(max_w);
        popCheck(ready_edge);
        popCheck(int'(retry_cnt));

        // ---- 4: lk drop in STABLE at timer=5 restarts qualification ----
        pushExpect("t4_stable_entry", RST_PULSE_CYC + 1);
        pushExpect("t4_state_rel5", 2);
        pushExpect("t4_state_rel6", 1);
        pushExpect("t4_state_rel7", 2);
        pushExpect("t4_pll_rst_cycles", 0);
        pushExpect("t4_ready_rel", 7 + STABLE_CYC);
        pushExpect("t4_retry", 0);
        pushExpect("t4_loss", 0);
        applyReset(1'b1);
        n = -1;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (state == 2'd2) begin
                n = i;
                break;
            end
        end
        popCheck(n);
        st5 = -1; st6 = -1; st7 = -1; prst = 0; back = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 3) pll_locked = 1'b0;
            if (i == 4) pll_locked = 1'b1;
            if (i == 5) st5 = int'(state);
            if (i == 6) st6 = int'(state);
            if (i == 7) st7 = int'(state);
            if (pll_rst) prst++;
            if (ready && back < 0) back = i;
        end
        popCheck(st5);
        popCheck(st6);
        popCheck(st7);
        popCheck(prst);
        popCheck(back);
        popCheck(int'(retry_cnt));
        popCheck(int'(loss_cnt));

        // ---- 6: saturate loss_cnt with 260 losses, then async reset in RUN ----
        pushExpect("t6_drops", 260);
        pushExpect("t6_timeouts", 0);
        pushExpect("t6_loss_sat", 255);
        pushExpect("t6_state_run", 3);
        pushExpect("t6_async_pll_rst", 1);
        pushExpect("t6_async_core_rst_n", 0);
        pushExpect("t6_async_ready", 0);
        pushExpect("t6_async_state", 0);
        pushExpect("t6_async_loss", 0);
        applyReset(1'b1);
        waitReady("t6_initial_ready_timeout", 50);
        drops = 0; timeouts = 0;
        for (int k = 0; k < 260; k++) begin
            pll_locked = 1'b0;
            repeat (LOW_LEN) tick();
            pll_locked = 1'b1;
            seen_low = 1'b0;
            for (int j = 0; j < 60; j++) begin
                tick();
                if (!ready) seen_low = 1'b1;
                if (seen_low && ready) break;
            end
            if (seen_low) drops++;
            if (!(seen_low && ready)) timeouts++;
        end
        popCheck(drops);
        popCheck(timeouts);
        popCheck(int'(loss_cnt));
        popCheck(int'(state));
        #2;
        rst_n = 1'b0;
        #1;
        popCheck(int'(pll_rst));
        popCheck(int'(core_rst_n));
        popCheck(int'(ready));
        popCheck(int'(state));
        popCheck(int'(loss_cnt));

        checkOutput("scoreboard_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
